// File: rtl/quad_pkg.sv
// Shared types for the quadrature decoder: control FSM states and the four Gray-code {A,B} levels.
package quad_pkg;

   typedef enum logic {INIT, RUN} state_t;

   localparam logic [1:0] gray_00 = 2'b00;
   localparam logic [1:0] gray_01 = 2'b01;
   localparam logic [1:0] gray_11 = 2'b11;
   localparam logic [1:0] gray_10 = 2'b10;

   // Successor of a level in the forward (count-up) direction.
   function automatic logic [1:0] gray_fwd(input logic [1:0] ab);
      logic [1:0] nxt;
      case (ab)
         gray_00: nxt = gray_01;
         gray_01: nxt = gray_11;
         gray_11: nxt = gray_10;
         default: nxt = gray_00;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/quad_filter.sv
// One channel: 2-flop synchronizer then a stability filter accepting a level held filt_len cycles.
// Latency raw->filtered is filt_len+1 edges after first sample; load overrides with the synced level.
module quad_filter #(
   parameter int filt_len = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   input  logic load,
   output logic synced,
   output logic filtered
);

   localparam int cw = $clog2(filt_len + 3);
   localparam logic [cw-1:0] cnt_last = cw'(filt_len - 1);

   logic          meta;
   logic [cw-1:0] count;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta     <= 1'b0;
         synced   <= 1'b0;
         filtered <= 1'b0;
         count    <= '0;
      end else begin
         meta   <= raw;
         synced <= meta;
         if (load) begin
            filtered <= synced;
            count    <= '0;
         end else if (synced == filtered) begin
            count <= '0;
         end else if (count == cnt_last) begin
            filtered <= synced;
            count    <= '0;
         end else begin
            count <= count + cw'(1);
         end
      end
   end

endmodule

// File: rtl/quad_decoder.sv
// Quadrature decoder: filtered A/B levels to en/dir step pulses plus a sticky illegal-transition flag.
// en rises filt_len+2 edges after a new level is first sampled; no backpressure, one step per cycle.
module quad_decoder
   import quad_pkg::*;
#(
   parameter int filt_len = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       a_in,
   input  logic       b_in,
   input  logic       clr_err,
   output logic       dir,
   output logic       en,
   output logic       err,
   output logic [1:0] ab_state
);

   localparam int cw = $clog2(filt_len + 3);
   localparam logic [cw-1:0] init_last = cw'(filt_len + 1);

   state_t        state, state_nxt;
   logic [cw-1:0] init_cnt, init_nxt;
   logic [1:0]    prev_ab;
   logic          load;
   logic          sync_a, sync_b, filt_a, filt_b;
   logic          step_en, step_dir, step_err;

   quad_filter #(.filt_len(filt_len)) u_filt_a (
      .clk      (clk),
      .rst      (rst),
      .raw      (a_in),
      .load     (load),
      .synced   (sync_a),
      .filtered (filt_a)
   );

   quad_filter #(.filt_len(filt_len)) u_filt_b (
      .clk      (clk),
      .rst      (rst),
      .raw      (b_in),
      .load     (load),
      .synced   (sync_b),
      .filtered (filt_b)
   );

   assign ab_state = {filt_a, filt_b};

   always_comb begin
      state_nxt = state;
      init_nxt  = init_cnt;
      load      = 1'b0;
      step_en   = 1'b0;
      step_dir  = dir;
      step_err  = 1'b0;
      case (state)
         INIT: begin
            // Let the synchronizers settle before seeding the filters and prev_ab.
            init_nxt = init_cnt + cw'(1);
            if (init_cnt == init_last) begin
               load      = 1'b1;
               state_nxt = RUN;
               init_nxt  = '0;
            end
         end
         RUN: begin
            if (ab_state == gray_fwd(prev_ab)) begin
               step_en  = 1'b1;
               step_dir = 1'b1;
            end else if (prev_ab == gray_fwd(ab_state)) begin
               step_en  = 1'b1;
               step_dir = 1'b0;
            end else if ((ab_state ^ prev_ab) == 2'b11) begin
               step_err = 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= INIT;
         init_cnt <= '0;
         prev_ab  <= '0;
         en       <= 1'b0;
         dir      <= 1'b0;
         err      <= 1'b0;
      end else begin
         state    <= state_nxt;
         init_cnt <= init_nxt;
         if (load) begin
            prev_ab <= {sync_a, sync_b};
         end else if (state == RUN) begin
            prev_ab <= ab_state;
         end
         en  <= step_en;
         dir <= step_dir;
         // A new illegal transition wins over a coincident clear.
         if (step_err) begin
            err <= 1'b1;
         end else if (clr_err) begin
            err <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_quad_decoder.sv
// Bench for quad_decoder (filt_len=4): directed vector table, reset corners, and randomized
// stimulus compared every cycle against a window-based behavioural model.
module tb_quad_decoder;

   localparam int FL = 4;

   logic       clk = 1'b0;
   logic       rst, a_in, b_in, clr_err;
   logic       dir, en, err;
   logic [1:0] ab_state;

   quad_decoder #(.filt_len(FL)) dut (
      .clk      (clk),
      .rst      (rst),
      .a_in     (a_in),
      .b_in     (b_in),
      .clr_err  (clr_err),
      .dir      (dir),
      .en       (en),
      .err      (err),
      .ab_state (ab_state)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err    = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Behavioural model: a level is accepted once the last FL raw samples
   // (seen two edges late through the synchronizer) all differ from it.
   bit         m_qa[$], m_qb[$];
   logic [1:0] m_filt, m_prev;
   bit         m_en, m_dir, m_err;
   int         m_edges;
   bit         model_on = 1'b0;

   function automatic int gpos(input logic [1:0] v);
      case (v)
         2'b00:   return 0;
         2'b01:   return 1;
         2'b11:   return 2;
         default: return 3;
      endcase
   endfunction

   function automatic logic [1:0] gval(input int p);
      case (p % 4)
         0:       return 2'b00;
         1:       return 2'b01;
         2:       return 2'b11;
         default: return 2'b10;
      endcase
   endfunction

   function automatic bit win_all(input bit q[$], input bit v);
      for (int i = 0; i < FL; i++) if (q[i] != v) return 1'b0;
      return 1'b1;
   endfunction

   task automatic model_step();
      bit         ra, rb;
      logic [1:0] nf, syn;
      int         d;
      ra = a_in;
      rb = b_in;
      if (rst) begin
         m_qa.delete();
         m_qb.delete();
         for (int i = 0; i <= FL; i++) begin
            m_qa.push_back(1'b0);
            m_qb.push_back(1'b0);
         end
         m_filt = 2'b00; m_prev = 2'b00;
         m_en = 1'b0; m_dir = 1'b0; m_err = 1'b0;
         m_edges = 0;
         return;
      end
      if (m_qa.size() != FL + 1) return;
      nf = m_filt;
      if (win_all(m_qa, !m_filt[1])) nf[1] = !m_filt[1];
      if (win_all(m_qb, !m_filt[0])) nf[0] = !m_filt[0];
      syn = {m_qa[FL-1], m_qb[FL-1]};
      if (m_edges < 1000000) m_edges++;
      m_en = 1'b0;
      if (m_edges == FL + 2) begin
         m_filt = syn;
         m_prev = syn;
      end else if (m_edges < FL + 2) begin
         m_filt = nf;
      end else begin
         d = (gpos(m_filt) - gpos(m_prev)) & 3;
         if (d == 1) begin m_en = 1'b1; m_dir = 1'b1; end
         else if (d == 3) begin m_en = 1'b1; m_dir = 1'b0; end
         if (d == 2) m_err = 1'b1;
         else if (clr_err) m_err = 1'b0;
         m_prev = m_filt;
         m_filt = nf;
      end
      m_qa.push_back(ra); void'(m_qa.pop_front());
      m_qb.push_back(rb); void'(m_qb.pop_front());
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   task automatic cyc();
      @(negedge clk);
      if (model_on) begin
         check("model_en",  en,       m_en);
         check("model_dir", dir,      m_dir);
         check("model_err", err,      m_err);
         check("model_ab",  ab_state, m_filt);
      end
   endtask

   typedef struct {
      logic [1:0] ab;
      int         hold;
      int         clr_at;
      logic [1:0] exp_ab;
      int         exp_pulses;
      int         exp_first;
      logic       exp_dir;
      logic       exp_err;
   } row_t;

   row_t tbl[$];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int pulses, first, noisy;
      logic [1:0] nxt;

      //          ab     hold clr  exp_ab pulses first dir   err
      tbl.push_back('{2'b01, 10, 0, 2'b01, 1, 7, 1'b1, 1'b0});
      tbl.push_back('{2'b11, 10, 0, 2'b11, 1, 7, 1'b1, 1'b0});
      tbl.push_back('{2'b10, 10, 0, 2'b10, 1, 7, 1'b1, 1'b0});
      tbl.push_back('{2'b00, 10, 0, 2'b00, 1, 7, 1'b1, 1'b0});
      tbl.push_back('{2'b10, 10, 0, 2'b10, 1, 7, 1'b0, 1'b0});
      tbl.push_back('{2'b11, 10, 0, 2'b11, 1, 7, 1'b0, 1'b0});
      tbl.push_back('{2'b01, 10, 0, 2'b01, 1, 7, 1'b0, 1'b0});
      tbl.push_back('{2'b00, 10, 0, 2'b00, 1, 7, 1'b0, 1'b0});
      tbl.push_back('{2'b00, 10, 0, 2'b00, 0, 0, 1'b0, 1'b0});
      tbl.push_back('{2'b10,  3, 0, 2'b00, 0, 0, 1'b0, 1'b0});
      tbl.push_back('{2'b00, 10, 0, 2'b00, 0, 0, 1'b0, 1'b0});
      tbl.push_back('{2'b10,  4, 0, 2'b00, 0, 0, 1'b0, 1'b0});
      tbl.push_back('{2'b00, 10, 0, 2'b00, 2, 3, 1'b1, 1'b0});
      tbl.push_back('{2'b11, 10, 0, 2'b11, 0, 0, 1'b1, 1'b1});
      tbl.push_back('{2'b11, 10, 0, 2'b11, 0, 0, 1'b1, 1'b1});
      tbl.push_back('{2'b11,  3, 1, 2'b11, 0, 0, 1'b1, 1'b0});
      tbl.push_back('{2'b00, 10, 7, 2'b00, 0, 0, 1'b1, 1'b1});
      tbl.push_back('{2'b00,  3, 1, 2'b00, 0, 0, 1'b1, 1'b0});

      // Reset release with both inputs high.
      rst = 1'b1; a_in = 1'b1; b_in = 1'b1; clr_err = 1'b0;
      repeat (3) @(negedge clk);
      model_on = 1'b1;
      check("rst_ab",  ab_state, 2'b00);
      check("rst_en",  en,  1'b0);
      check("rst_dir", dir, 1'b0);
      check("rst_err", err, 1'b0);
      rst = 1'b0;
      noisy = 0;
      for (int j = 1; j <= 10; j++) begin
         cyc();
         if (en || err) noisy++;
         if (j == 5) check("init_ab_edge5", ab_state, 2'b00);
         if (j == 6) check("init_ab_edge6", ab_state, 2'b11);
      end
      check("init_quiet", noisy, 0);

      rst = 1'b1; a_in = 1'b0; b_in = 1'b0;
      cyc();
      rst = 1'b0;
      repeat (8) cyc();

      foreach (tbl[r]) begin
         a_in = tbl[r].ab[1];
         b_in = tbl[r].ab[0];
         pulses = 0;
         first  = 0;
         for (int j = 1; j <= tbl[r].hold; j++) begin
            clr_err = (j == tbl[r].clr_at);
            cyc();
            if (en) begin
               pulses++;
               if (first == 0) first = j;
            end
         end
         clr_err = 1'b0;
         check($sformatf("row%0d_ab", r),     ab_state, tbl[r].exp_ab);
         check($sformatf("row%0d_pulses", r), pulses,   tbl[r].exp_pulses);
         check($sformatf("row%0d_first", r),  first,    tbl[r].exp_first);
         check($sformatf("row%0d_dir", r),    dir,      tbl[r].exp_dir);
         check($sformatf("row%0d_err", r),    err,      tbl[r].exp_err);
      end

      // Reset in the middle of the second forward step.
      a_in = 1'b0; b_in = 1'b1;
      pulses = 0;
      repeat (10) begin cyc(); if (en) pulses++; end
      check("mid_first_step", pulses, 1);
      a_in = 1'b1;
      repeat (4) cyc();
      rst = 1'b1;
      cyc();
      check("mid_rst_en",  en,  1'b0);
      check("mid_rst_dir", dir, 1'b0);
      check("mid_rst_err", err, 1'b0);
      check("mid_rst_ab",  ab_state, 2'b00);
      rst = 1'b0;
      noisy = 0;
      repeat (12) begin cyc(); if (en || err) noisy++; end
      check("mid_rst_quiet", noisy, 0);
      check("mid_rst_ab_after", ab_state, 2'b11);

      // Randomized walk, mostly legal steps, with glitches, clears and rare resets.
      for (int s = 0; s < 300; s++) begin
         int pick, hold, p;
         pick = $urandom_range(0, 6);
         p = gpos({a_in, b_in});
         case (pick)
            0, 1, 2: nxt = gval(p + 1);
            3, 4:    nxt = gval(p + 3);
            5:       nxt = gval(p + 2);
            default: nxt = {a_in, b_in};
         endcase
         a_in = nxt[1];
         b_in = nxt[0];
         hold = $urandom_range(1, 12);
         for (int j = 0; j < hold; j++) begin
            clr_err = ($urandom_range(0, 19) == 0);
            rst     = ($urandom_range(0, 299) == 0);
            cyc();
         end
      end
      rst = 1'b0;
      clr_err = 1'b0;
      repeat (3) cyc();

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/quad_decoder.md
QUAD_DECODER -- requirements
Module: quad_decoder

Interface
REQ-001 Parameter filt_len, default 16, is the number of consecutive cycles a synchronized input must hold a new level before it is accepted; legal range 2..255.
REQ-002 Port clk  input  1  is the single clock; all state updates on its rising edge.
REQ-003 Port rst  input  1  is the reset: synchronous, active-high.
REQ-004 Port a_in  input  1  is quadrature channel A, asynchronous to clk.
REQ-005 Port b_in  input  1  is quadrature channel B, asynchronous to clk.
REQ-006 Port clr_err  input  1  clears the sticky error flag.
REQ-007 Port dir  output  1  is the direction of the last valid step: 1 = forward, 0 = reverse.
REQ-008 Port en  output  1  is a one-cycle pulse per valid step, directly compatible with an up/down counter's en/dir inputs.
REQ-009 Port err  output  1  is the sticky illegal-transition flag.
REQ-010 Port ab_state  output  2  is the filtered {A,B} level.

Function
REQ-011 Each input SHALL pass a 2-flop synchronizer before any other use.
REQ-012 Per-channel filter: synced == filtered clears the stability count; synced != filtered increments it; at count == filt_len-1 with synced still != filtered, filtered <= synced and count <= 0.
REQ-013 Control FSM states: INIT, RUN; rst forces INIT and clears the init counter.
REQ-014 INIT SHALL last filt_len+2 cycles, then load both filters and prev_ab from the synchronized inputs, clear the filter counts, and enter RUN; en and err stay 0 in INIT.
REQ-015 In RUN, each cycle compares filtered {A,B} with registered prev_ab, then sets prev_ab <= filtered.
REQ-016 Forward Gray sequence 00->01->11->10->00 SHALL give en=1 and dir=1 on the next edge.
REQ-017 Reverse sequence 00->10->11->01->00 SHALL give en=1 and dir=0 on the next edge.
REQ-018 Both bits changing in one cycle is an illegal transition: set err; no en pulse; dir unchanged.
REQ-019 No change: en=0.
REQ-020 en SHALL never stay high longer than one cycle, and SHALL never be high in the same cycle as an err-setting event.
REQ-021 dir SHALL hold its value between valid steps.
REQ-022 Latency: with k the first edge that samples a new a_in/b_in level, en SHALL assert on edge k+filt_len+2.
REQ-023 err clears on the edge after clr_err=1 only; if clr_err and a new illegal transition coincide, set wins and err stays 1.
REQ-024 ab_state SHALL equal the filtered levels at all times.

Reset
REQ-025 On an rst edge: dir=0, en=0, err=0, ab_state=00, filter counts 0, synchronizers 0, FSM=INIT.
REQ-026 rst asserted mid-sequence SHALL abort any pending filter count, and outputs SHALL reach reset values on that same edge.

Structure
REQ-027 Package quad_pkg SHALL hold the FSM state enum (INIT, RUN) and the four Gray-code state constants.
REQ-028 Sub-module quad_filter (synchronizer + stability filter + load port) SHALL be instantiated once per channel.
REQ-029 Filter and init counter widths SHALL be $clog2(filt_len+3).

Verification (filt_len=4)
REQ-030 Reset release with a_in=b_in=1 -> after 6 cycles ab_state=11; en and err never assert.
REQ-031 Forward sequence 00,01,11,10,00, each held 10 cycles -> exactly 4 single-cycle en pulses, each at k+6, dir=1, err=0.
REQ-032 Reverse sequence 00,10,11,01,00 -> 4 en pulses, dir=0 and held afterwards.
REQ-033 3-cycle glitch on a_in -> no en, ab_state unchanged; 4-cycle pulse -> accepted.
REQ-034 Simultaneous 00->11 -> err=1 and no en; clr_err one cycle -> err=0 next edge; clr_err coincident with a new 11->00 -> err stays 1.
REQ-035 rst pulsed during the second step of a forward sequence -> outputs zero on the next edge, INIT reruns, no spurious en or err.
